calc_keypad: RTL and testbench

CALC_KEYPAD -- requirements
Module: calc_keypad

---
 rtl/calc_keypad.sv | 235 +++++++++++++++++++++++
 tb/tb_calc_keypad.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_keypad.sv
// 4x5 calculator keypad scanner: rotates an active-low column strobe, classifies
// each full scan frame and debounces single-key presses/releases into a code pulse.
module calc_keypad #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [3:0] i_row,
    output logic [4:0] o_col,
    output logic       o_key_valid,
    output logic [4:0] o_bcd_data,
    output logic       o_key_down
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_C     = DW'(DEB_FRAMES);
    localparam logic [DW-1:0] ONE_C     = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    function automatic logic [4:0] key_code(input logic [4:0] idx);
        logic [4:0] code;
        case (idx)
            5'd0:    code = 5'h07;
            5'd1:    code = 5'h08;
            5'd2:    code = 5'h09;
            5'd3:    code = 5'h10;
            5'd4:    code = 5'h16;
            5'd5:    code = 5'h04;
            5'd6:    code = 5'h05;
            5'd7:    code = 5'h06;
            5'd8:    code = 5'h11;
            5'd9:    code = 5'h17;
            5'd10:   code = 5'h01;
            5'd11:   code = 5'h02;
            5'd12:   code = 5'h03;
            5'd13:   code = 5'h12;
            5'd14:   code = 5'h18;
            5'd15:   code = 5'h14;
            5'd16:   code = 5'h00;
            5'd17:   code = 5'h15;
            5'd18:   code = 5'h13;
            5'd19:   code = 5'h19;
            default: code = 5'h00;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_q, row_sync_q;
    logic [SW-1:0] slot_q;
    logic [2:0]    col_idx_q;
    logic [4:0]    col_q;
    logic [1:0]    acc_cnt_q;
    logic [4:0]    acc_idx_q;
    state_t        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [4:0]    cand_q, cand_d;
    logic          valid_q, valid_d;
    logic [4:0]    bcd_q, bcd_d;
    logic          down_q, down_d;

    logic [3:0] pressed_s;
    logic [2:0] col_cnt_s;
    logic [2:0] tot_s;
    logic [1:0] hit_row_s;
    logic [4:0] hit_idx_s;
    logic [4:0] frame_idx_s;
    logic       slot_end_s, frame_end_s, cls_none_s, cls_single_s;

    assign slot_end_s   = (slot_q == SLOT_LAST);
    assign frame_end_s  = slot_end_s && (col_idx_q == 3'd4);
    assign pressed_s    = ~row_sync_q;
    assign col_cnt_s    = 3'(pressed_s[0]) + 3'(pressed_s[1]) + 3'(pressed_s[2]) + 3'(pressed_s[3]);
    assign tot_s        = {1'b0, acc_cnt_q} + col_cnt_s;
    assign hit_idx_s    = 5'(hit_row_s) * 5'd5 + 5'(col_idx_q);
    assign frame_idx_s  = ((acc_cnt_q == 2'd0) && (col_cnt_s == 3'd1)) ? hit_idx_s : acc_idx_q;
    assign cls_none_s   = (tot_s == 3'd0);
    assign cls_single_s = (tot_s == 3'd1);

    // Row of the lowest pressed key in the current column (only used when exactly one is low).
    always_comb begin
        hit_row_s = 2'd0;
        casez (pressed_s)
            4'b???1: hit_row_s = 2'd0;
            4'b??10: hit_row_s = 2'd1;
            4'b?100: hit_row_s = 2'd2;
            4'b1000: hit_row_s = 2'd3;
            default: hit_row_s = 2'd0;
        endcase
    end

    // Two-flop row synchronizer; idle value is all rows released.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= i_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Column slot timing and one-hot active-low strobe rotation.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            slot_q    <= '0;
            col_idx_q <= 3'd0;
            col_q     <= 5'b11110;
        end else if (slot_end_s) begin
            slot_q    <= '0;
            col_idx_q <= (col_idx_q == 3'd4) ? 3'd0 : col_idx_q + 3'd1;
            col_q     <= {col_q[3:0], col_q[4]};
        end else begin
            slot_q    <= slot_q + SW'(1);
        end
    end

    // Per-frame key tally: saturating count of low rows plus index of the first hit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_cnt_q <= 2'd0;
            acc_idx_q <= 5'd0;
        end else if (frame_end_s) begin
            acc_cnt_q <= 2'd0;
            acc_idx_q <= 5'd0;
        end else if (slot_end_s) begin
            acc_cnt_q <= (tot_s >= 3'd2) ? 2'd2 : tot_s[1:0];
            acc_idx_q <= frame_idx_s;
        end else begin
            acc_cnt_q <= acc_cnt_q;
            acc_idx_q <= acc_idx_q;
        end
    end

    // Debounce FSM, evaluated only on the last cycle of a frame.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        cand_d    = cand_q;
        valid_d   = 1'b0;
        bcd_d     = bcd_q;
        if (frame_end_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (cls_single_s) begin
                        cand_d    = frame_idx_s;
                        deb_cnt_d = ONE_C;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cls_single_s) begin
                        deb_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else if (frame_idx_s == cand_q) begin
                        deb_cnt_d = deb_cnt_q + ONE_C;
                    end else begin
                        cand_d    = frame_idx_s;
                        deb_cnt_d = ONE_C;
                    end
                end
                ST_PRESSED: begin
                    if (cls_none_s) begin
                        deb_cnt_d = ONE_C;
                        state_d   = ST_RELEASE;
                    end else begin
                        state_d   = ST_PRESSED;
                    end
                end
                ST_RELEASE: begin
                    if (cls_none_s) begin
                        deb_cnt_d = deb_cnt_q + ONE_C;
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = ST_PRESSED;
                    end
                end
                default: begin
                    deb_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase
            // Reaching the threshold is checked on the updated count so DEB_FRAMES=1 accepts at once.
            if ((state_d == ST_DEBOUNCE) && (deb_cnt_d == DEB_C)) begin
                state_d   = ST_PRESSED;
                deb_cnt_d = '0;
                valid_d   = 1'b1;
                bcd_d     = key_code(cand_d);
            end else if ((state_d == ST_RELEASE) && (deb_cnt_d == DEB_C)) begin
                state_d   = ST_IDLE;
                deb_cnt_d = '0;
            end else begin
                state_d   = state_d;
            end
        end else begin
            state_d = state_q;
        end
        down_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
            cand_q    <= 5'd0;
            valid_q   <= 1'b0;
            bcd_q     <= 5'h00;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            cand_q    <= cand_d;
            valid_q   <= valid_d;
            bcd_q     <= bcd_d;
            down_q    <= down_d;
        end
    end

    assign o_col       = col_q;
    assign o_key_valid = valid_q;
    assign o_bcd_data  = bcd_q;
    assign o_key_down  = down_q;

endmodule

// File: tb/tb_calc_keypad.sv
// Bench for calc_keypad: a keypad matrix model drives two scanners (DEB_FRAMES 3 and 1)
// frame by frame; a run-length debounce model predicts pulses, codes and key_down.
module tb_calc_keypad;

    logic        clk;
    logic        rstn;
    logic [3:0]  row;
    logic [19:0] keys;
    logic [4:0]  col_a, col_b, bcd_a, bcd_b;
    logic        vld_a, vld_b, dn_a, dn_b;

    int total = 0;
    int bad   = 0;

    logic [4:0] tbl [20] = '{5'h07, 5'h08, 5'h09, 5'h10, 5'h16,
                             5'h04, 5'h05, 5'h06, 5'h11, 5'h17,
                             5'h01, 5'h02, 5'h03, 5'h12, 5'h18,
                             5'h14, 5'h00, 5'h15, 5'h13, 5'h19};

    int         deb_m    [2] = '{3, 1};
    bit         down_m   [2];
    bit         pulse_m  [2];
    int         run_key  [2];
    int         run_len  [2];
    int         none_len [2];
    logic [4:0] code_m   [2];

    calc_keypad #(.SCAN_DIV(4), .DEB_FRAMES(3)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_row(row), .o_col(col_a),
        .o_key_valid(vld_a), .o_bcd_data(bcd_a), .o_key_down(dn_a));

    calc_keypad #(.SCAN_DIV(4), .DEB_FRAMES(1)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_row(row), .o_col(col_b),
        .o_key_valid(vld_b), .o_bcd_data(bcd_b), .o_key_down(dn_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (keys[r*5+c] && !col_a[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m, input int n, input int idx);
        pulse_m[m] = 1'b0;
        if (!down_m[m]) begin
            if (n == 1) begin
                if (run_len[m] > 0 && idx == run_key[m]) run_len[m]++;
                else begin
                    run_key[m] = idx;
                    run_len[m] = 1;
                end
                if (run_len[m] >= deb_m[m]) begin
                    pulse_m[m]  = 1'b1;
                    down_m[m]   = 1'b1;
                    code_m[m]   = tbl[idx];
                    run_len[m]  = 0;
                    none_len[m] = 0;
                end
            end else begin
                run_len[m] = 0;
            end
        end else begin
            if (n == 0) begin
                none_len[m]++;
                if (none_len[m] >= deb_m[m]) begin
                    down_m[m]   = 1'b0;
                    none_len[m] = 0;
                end
            end else begin
                none_len[m] = 0;
            end
        end
    endtask

    task automatic run_frame(input logic [19:0] k);
        int         n;
        int         idx;
        logic [4:0] ecol;
        keys = k;
        n    = $countones(k);
        idx  = 0;
        for (int i = 19; i >= 0; i--) if (k[i]) idx = i;
        for (int m = 0; m < 2; m++) model_step(m, n, idx);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            ecol = ~(5'b00001 << ((i % 20) / 4));
            check("col_a", {27'd0, col_a}, {27'd0, ecol});
            check("col_b", {27'd0, col_b}, {27'd0, ecol});
            if (i < 20) begin
                check("valid_a_quiet", {31'd0, vld_a}, 32'd0);
                check("valid_b_quiet", {31'd0, vld_b}, 32'd0);
            end else begin
                check("valid_a", {31'd0, vld_a}, {31'd0, pulse_m[0]});
                check("valid_b", {31'd0, vld_b}, {31'd0, pulse_m[1]});
                check("bcd_a", {27'd0, bcd_a}, {27'd0, code_m[0]});
                check("bcd_b", {27'd0, bcd_b}, {27'd0, code_m[1]});
                check("down_a", {31'd0, dn_a}, {31'd0, down_m[0]});
                check("down_b", {31'd0, dn_b}, {31'd0, down_m[1]});
            end
        end
    endtask

    task automatic frames(input logic [19:0] k, input int cnt);
        for (int f = 0; f < cnt; f++) run_frame(k);
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rstn = 1'b0;
        for (int m = 0; m < 2; m++) begin
            down_m[m]   = 1'b0;
            pulse_m[m]  = 1'b0;
            run_len[m]  = 0;
            none_len[m] = 0;
            run_key[m]  = 0;
            code_m[m]   = 5'h00;
        end
        repeat (cyc) @(posedge clk);
        #1;
        check("rst_col_a", {27'd0, col_a}, 32'h1E);
        check("rst_col_b", {27'd0, col_b}, 32'h1E);
        check("rst_valid_a", {31'd0, vld_a}, 32'd0);
        check("rst_valid_b", {31'd0, vld_b}, 32'd0);
        check("rst_bcd_a", {27'd0, bcd_a}, 32'd0);
        check("rst_bcd_b", {27'd0, bcd_b}, 32'd0);
        check("rst_down_a", {31'd0, dn_a}, 32'd0);
        check("rst_down_b", {31'd0, dn_b}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    localparam logic [19:0] K_NONE = 20'd0;
    localparam logic [19:0] K_7    = 20'd1 << 0;
    localparam logic [19:0] K_8    = 20'd1 << 1;
    localparam logic [19:0] K_5    = 20'd1 << 6;
    localparam logic [19:0] K_ESC  = 20'd1 << 15;
    localparam logic [19:0] K_0    = 20'd1 << 16;
    localparam logic [19:0] K_ENT  = 20'd1 << 17;
    localparam logic [19:0] K_PLUS = 20'd1 << 18;

    initial begin
        logic [19:0] cur;
        int          r, a, b;
        rstn = 1'b0;
        keys = K_NONE;
        do_reset(3);

        // Steady '5', then release.
        frames(K_5, 10);
        frames(K_NONE, 3);
        // Bouncing Ent, then steady.
        run_frame(K_ENT); run_frame(K_NONE); run_frame(K_ENT); run_frame(K_NONE);
        frames(K_ENT, 5);
        frames(K_NONE, 3);
        // Two keys together.
        frames(K_7 | K_PLUS, 6);
        frames(K_NONE, 3);
        // Roll-over from '7' to '8'.
        frames(K_7, 4);
        frames(K_7 | K_8, 2);
        frames(K_8, 3);
        frames(K_NONE, 3);
        // Short release of '0'.
        frames(K_0, 4);
        frames(K_NONE, 2);
        frames(K_0, 3);
        frames(K_NONE, 3);
        // Reset in the middle of debouncing ESC.
        frames(K_ESC, 2);
        do_reset(3);
        frames(K_ESC, 4);
        frames(K_NONE, 3);

        // Random frames.
        cur = K_NONE;
        for (int f = 0; f < 80; f++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                cur = K_NONE;
            end else if (r <= 6) begin
                if ($countones(cur) != 1) cur = 20'd1 << $urandom_range(0, 19);
            end else if (r <= 8) begin
                cur = 20'd1 << $urandom_range(0, 19);
            end else begin
                a   = $urandom_range(0, 19);
                b   = (a + 1 + $urandom_range(0, 18)) % 20;
                cur = (20'd1 << a) | (20'd1 << b);
            end
            run_frame(cur);
        end
        frames(K_NONE, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
